i2c_target: RTL

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target exposing a 16x8 register file to both the bus and a host port
module i2c_target #(
    parameter logic [6:0] DEVICE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic       read,
    input  logic       write,
    input  logic [3:0] address,
    input  logic [7:0] dataIn,
    output logic       readValid,
    output logic [7:0] dataOut,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  scl_sync_q, scl_sync_d;
    logic [2:0]  sda_sync_q, sda_sync_d;
    logic        sda_oe_q, sda_oe_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        rw_q, rw_d;
    logic        mack_q, mack_d;
    logic        busy_q, busy_d;
    logic        read_valid_q, read_valid_d;
    logic [7:0]  data_out_q, data_out_d;
    logic [7:0]  mem_q [16];
    logic [7:0]  mem_d [16];

    // Index 1 is the synchronized level, index 2 the previous synchronized level
    logic       scl_rise, scl_fall, start_det, stop_det, byte_done;
    logic [7:0] rx_byte;

    assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
    assign start_det = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_sync_q[1];
    assign stop_det  = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_sync_q[1];
    assign rx_byte   = {shift_q[6:0], sda_sync_q[1]};
    assign byte_done = scl_rise && (bit_cnt_q == 4'd7);

    // Open-drain: only ever pull low or release
    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign readValid = read_valid_q;
    assign dataOut   = data_out_q;
    assign busy      = busy_q;

    // Next-state logic: host port, bus protocol FSM, shared register file
    always_comb begin
        state_d      = state_q;
        scl_sync_d   = {scl_sync_q[1:0], scl};
        sda_sync_d   = {sda_sync_q[1:0], sda};
        sda_oe_d     = sda_oe_q;
        ptr_d        = ptr_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rw_d         = rw_q;
        mack_d       = mack_q;
        busy_d       = busy_q;
        mem_d        = mem_q;
        read_valid_d = read;
        data_out_d   = read ? mem_q[address] : data_out_q;

        // Host write first so a same-location bus write below overrides it
        if (write) mem_d[address] = dataIn;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (byte_done) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == ADDR) begin
                            rw_d    = rx_byte[0];
                            state_d = (rx_byte[7:1] == DEVICE_ADDR) ? ADDR_ACK : IDLE;
                        end else if (state_q == PTR) begin
                            ptr_d   = rx_byte[3:0];
                            state_d = PTR_ACK;
                        end else begin
                            mem_d[ptr_q] = rx_byte;
                            ptr_d        = ptr_q + 4'd1;
                            state_d      = WDATA_ACK;
                        end
                    end
                end
                // First falling edge starts the ACK, second one ends it
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                shift_d  = mem_q[ptr_q];
                                sda_oe_d = ~mem_q[ptr_q][7];
                                state_d  = RDATA;
                            end else if (state_q == ADDR_ACK) begin
                                state_d = PTR;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            ptr_d     = ptr_q + 4'd1;
                            bit_cnt_d = 4'd0;
                            state_d   = RDATA_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) mack_d = sda_sync_q[1];
                    if (scl_fall) begin
                        if (!mack_q) begin
                            shift_d   = mem_q[ptr_q];
                            sda_oe_d  = ~mem_q[ptr_q][7];
                            bit_cnt_d = 4'd0;
                            state_d   = RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = IDLE;
                        end
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                    state_d  = IDLE;
                end
            endcase
        end
    end

    // All state registers; reset releases sda at once and clears the register file
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            scl_sync_q   <= 3'b111;
            sda_sync_q   <= 3'b111;
            sda_oe_q     <= 1'b0;
            ptr_q        <= 4'd0;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'h00;
            rw_q         <= 1'b0;
            mack_q       <= 1'b1;
            busy_q       <= 1'b0;
            read_valid_q <= 1'b0;
            data_out_q   <= 8'h00;
            for (int i = 0; i < 16; i++) mem_q[i] <= 8'h00;
        end else begin
            state_q      <= state_d;
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            sda_oe_q     <= sda_oe_d;
            ptr_q        <= ptr_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rw_q         <= rw_d;
            mack_q       <= mack_d;
            busy_q       <= busy_d;
            read_valid_q <= read_valid_d;
            data_out_q   <= data_out_d;
            for (int i = 0; i < 16; i++) mem_q[i] <= mem_d[i];
        end
    end

endmodule
